// File: rtl/img_link_pkg.sv
// Shared types and default sizing for the image link host.
package img_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_RES,
    TX_FETCH,
    TX_SEND,
    TX_WAIT,
    FIN
  } state_t;

  localparam int unsigned IMG_DIM        = 28;
  localparam int unsigned N_PIX_DEF      = IMG_DIM * IMG_DIM;
  localparam int unsigned N_OUT_DEF      = 10;
  localparam int unsigned WORD_BYTES_DEF = 4;

endpackage

// File: rtl/link_word_asm.sv
// Assembles LSB-first result bytes into words and strobes each completed word.
module link_word_asm
  import img_link_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter int unsigned N_OUT      = N_OUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        res_valid,
  output logic [3:0]  res_idx,
  output logic [31:0] res_word
);

  localparam int unsigned LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [LW-1:0] lane;
  logic [3:0]    word_cnt;
  logic [31:0]   acc;
  logic [31:0]   acc_nx;
  logic          lane_last;

  assign lane_last = (lane == LW'(WORD_BYTES - 1));
  // Final byte of the final word: lets the FSM leave RX_RES on the same edge.
  assign last_byte = byte_valid && lane_last && (word_cnt == 4'(N_OUT - 1));

  always_comb begin
    acc_nx = acc;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane == LW'(i)) acc_nx[8*i +: 8] = byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane      <= '0;
      word_cnt  <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_word  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (clear) begin
        lane     <= '0;
        word_cnt <= '0;
        acc      <= '0;
      end else if (byte_valid) begin
        acc <= acc_nx;
        if (lane_last) begin
          lane      <= '0;
          word_cnt  <= word_cnt + 4'd1;
          res_valid <= 1'b1;
          res_idx   <= word_cnt;
          res_word  <= acc_nx;
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/image_link_host.sv
// Host side of the trainer link: collects the result block, then streams one image.
module image_link_host
  import img_link_pkg::*;
#(
  parameter int unsigned N_PIX      = N_PIX_DEF,
  parameter int unsigned N_OUT      = N_OUT_DEF,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter int unsigned RX_TIMEOUT = 50_000_000,
  parameter int unsigned RX_FIRST   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [9:0]  pix_addr,
  input  logic [7:0]  pix_data,
  output logic        res_valid,
  output logic [3:0]  res_idx,
  output logic [31:0] res_word,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned IW = $clog2(RX_TIMEOUT + 1);

  state_t        state, state_nx;
  logic [9:0]    pix_cnt;
  logic [IW-1:0] idle_cnt;
  logic          fetch_ph;
  logic          hold;
  logic          accept;
  logic          byte_valid;
  logic          last_byte;
  logic          rx_timeout;
  logic          pix_last;

  assign accept     = (state == IDLE) && go;
  assign byte_valid = (state == RX_RES) && rx_valid;
  assign rx_timeout = (state == RX_RES) && !rx_valid && (idle_cnt == IW'(RX_TIMEOUT - 1));
  assign pix_last   = (pix_cnt == 10'(N_PIX - 1));
  assign pix_addr   = pix_cnt;

  link_word_asm #(
    .WORD_BYTES(WORD_BYTES),
    .N_OUT     (N_OUT)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .byte_valid(byte_valid),
    .byte_data (rx_data),
    .last_byte (last_byte),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_word  (res_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE) && (state != FIN);
    unique case (state)
      IDLE:     if (go) state_nx = (RX_FIRST != 0) ? RX_RES : TX_FETCH;
      // A timeout reuses FIN so done/busy behave exactly as on normal completion.
      RX_RES: begin
        if (rx_timeout)     state_nx = FIN;
        else if (last_byte) state_nx = TX_FETCH;
      end
      TX_FETCH: if (fetch_ph) state_nx = TX_SEND;
      TX_SEND: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_nx = TX_WAIT;
        end
      end
      TX_WAIT:  if (!hold && tx_ready) state_nx = pix_last ? FIN : TX_FETCH;
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      idle_cnt    <= '0;
      fetch_ph    <= 1'b0;
      hold        <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      fetch_ph <= (state == TX_FETCH) && !fetch_ph;
      hold     <= tx_start;
      if (accept) begin
        pix_cnt     <= '0;
        idle_cnt    <= '0;
        timeout_err <= 1'b0;
      end
      if (state == RX_RES) begin
        idle_cnt <= rx_valid ? '0 : idle_cnt + 1'b1;
        if (rx_timeout) timeout_err <= 1'b1;
        if (last_byte)  pix_cnt     <= '0;
      end
      // Second fetch cycle: RAM data for pix_addr is now valid.
      if ((state == TX_FETCH) && fetch_ph) tx_data <= pix_data;
      if ((state == TX_WAIT) && !hold && tx_ready && !pix_last) pix_cnt <= pix_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_image_link_host.sv
// Directed scoreboard bench: RX results, image TX, timeout, robustness, TX-only variant.
module tb_image_link_host;

  localparam int unsigned TX_GAP = 6;
  localparam int unsigned NP     = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, go, go_b, rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready, tx_start, res_valid, busy, done, timeout_err;
  logic [7:0]  tx_data, pix_data;
  logic [9:0]  pix_addr;
  logic [3:0]  res_idx;
  logic [31:0] res_word;
  logic        tx_ready_b, tx_start_b, res_valid_b, busy_b, done_b, timeout_err_b;
  logic [7:0]  tx_data_b, pix_data_b;
  logic [9:0]  pix_addr_b;
  logic [3:0]  res_idx_b;
  logic [31:0] res_word_b;

  int unsigned total = 0, bad = 0;
  int unsigned tx_count = 0, res_count = 0, done_count = 0;
  int unsigned txb_count = 0, resb_count = 0, doneb_count = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  txb_q[$];
  logic [35:0] res_q[$];

  image_link_host #(.RX_TIMEOUT(1000)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .pix_addr(pix_addr),
    .pix_data(pix_data), .res_valid(res_valid), .res_idx(res_idx), .res_word(res_word),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  image_link_host #(.RX_TIMEOUT(1000), .RX_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .pix_addr(pix_addr_b),
    .pix_data(pix_data_b), .res_valid(res_valid_b), .res_idx(res_idx_b), .res_word(res_word_b),
    .busy(busy_b), .done(done_b), .timeout_err(timeout_err_b)
  );

  // Pixel RAM with RAM[a] = a[7:0], one-cycle read latency
  always @(posedge clk) begin
    pix_data   <= pix_addr[7:0];
    pix_data_b <= pix_addr_b[7:0];
  end

  // uart_tx models: ready stays high one cycle after the strobe, then low TX_GAP cycles
  logic start_d = 1'b0, start_d_b = 1'b0;
  int unsigned gap_cnt = 0, gap_cnt_b = 0;
  always @(posedge clk) begin
    start_d   <= tx_start;
    start_d_b <= tx_start_b;
    if (start_d) gap_cnt <= TX_GAP;
    else if (gap_cnt != 0) gap_cnt <= gap_cnt - 1;
    if (start_d_b) gap_cnt_b <= TX_GAP;
    else if (gap_cnt_b != 0) gap_cnt_b <= gap_cnt_b - 1;
  end
  assign tx_ready   = (gap_cnt == 0);
  assign tx_ready_b = (gap_cnt_b == 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [35:0] er;
    if (rst_n === 1'b1) begin
      if (tx_start) begin
        tx_count++;
        check("tx_one_in_flight", 64'(!start_d && gap_cnt == 0), 1);
        check("tx_expected", 64'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
          eb = tx_q.pop_front();
          check("tx_byte", tx_data, eb);
        end
      end
      if (res_valid) begin
        res_count++;
        check("res_expected", 64'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          er = res_q.pop_front();
          check("res_idx_word", {res_idx, res_word}, er);
        end
      end
      if (done) begin
        done_count++;
        check("busy_low_at_done", busy, 0);
      end
      if (tx_start_b) begin
        txb_count++;
        check("b_tx_expected", 64'(txb_q.size() != 0), 1);
        if (txb_q.size() != 0) begin
          eb = txb_q.pop_front();
          check("b_tx_byte", tx_data_b, eb);
        end
      end
      if (res_valid_b) resb_count++;
      if (done_b) doneb_count++;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic push_frame();
    logic [9:0] k;
    for (int i = 0; i < 10; i++) res_q.push_back({4'(i), 32'h0001_8000});
    for (int i = 0; i < NP; i++) begin
      k = 10'(i);
      tx_q.push_back(k[7:0]);
    end
  endtask

  task automatic send_results();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h00); send_byte(8'h80); send_byte(8'h01); send_byte(8'h00);
    end
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (done_count < target && n < 20000) begin tick(1); n++; end
    check(tag, done_count, target);
  endtask

  task automatic wait_tx(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (tx_count < target && n < 20000) begin tick(1); n++; end
    check(tag, tx_count, target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, r0, d0, t1, n;
    logic [9:0] k;
    rst_n = 1'b0; go = 1'b1; go_b = 1'b1; rx_valid = 1'b0; rx_data = '0;

    // Reset held with go asserted: every output zero
    repeat (3) begin
      tick(1);
      check("reset_outputs", {tx_start, tx_data, pix_addr, res_valid, res_idx, res_word, busy, done, timeout_err}, 0);
      check("reset_outputs_b", {tx_start_b, tx_data_b, pix_addr_b, res_valid_b, res_idx_b, res_word_b, busy_b, done_b, timeout_err_b}, 0);
    end
    rst_n = 1'b1; go = 1'b0; go_b = 1'b0;
    tick(3);
    check("idle_after_reset", {busy, busy_b, tx_count[7:0]}, 0);

    // Full frame: 10 result words then 784 image bytes
    t0 = tx_count; r0 = res_count; d0 = done_count;
    push_frame();
    pulse_go();
    check("busy_after_go", busy, 1);
    send_results();
    check("res_words_received", res_count - r0, 10);
    wait_done(d0 + 1, "frame1_done");
    check("frame1_tx_bytes", tx_count - t0, NP);
    check("frame1_queues_empty", 64'(tx_q.size() + res_q.size()), 0);

    // Timeout: 5 bytes then silence
    t0 = tx_count; r0 = res_count; d0 = done_count;
    res_q.push_back({4'd0, 32'h4433_2211});
    pulse_go();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    rx_valid = 1'b1; rx_data = 8'h55;
    tick(1);
    rx_valid = 1'b0;
    n = 0;
    while (!timeout_err && n < 1100) begin tick(1); n++; end
    check("timeout_latency", n, 1000);
    tick(4);
    check("timeout_done_pulse", done_count - d0, 1);
    check("timeout_one_res", res_count - r0, 1);
    check("timeout_no_tx", tx_count - t0, 0);
    check("timeout_idle", {busy, timeout_err}, 2'b01);
    pulse_go();
    check("go_clears_timeout", timeout_err, 0);
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);

    // Robustness: go+rx together, go while busy, stray bytes during TX
    t0 = tx_count; r0 = res_count; d0 = done_count;
    push_frame();
    go = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    tick(1);
    go = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h00); send_byte(8'h80); send_byte(8'h01); send_byte(8'h00);
      if (i % 3 == 1) pulse_go();
    end
    wait_tx(t0 + 50, "robust_tx_progress");
    for (int i = 0; i < 5; i++) begin pulse_go(); send_byte(8'hA5); end
    wait_done(d0 + 1, "robust_done");
    check("robust_tx_bytes", tx_count - t0, NP);
    check("robust_res_words", res_count - r0, 10);
    tick(300);
    check("robust_no_extra_frame", {tx_count - t0, done_count - d0}, {32'(NP), 32'd1});
    check("robust_idle", busy, 0);

    // Reset at pixel 300 abandons the frame
    t0 = tx_count; d0 = done_count;
    push_frame();
    pulse_go();
    send_results();
    wait_tx(t0 + 300, "reset_mid_progress");
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    tx_q.delete();
    check("reset_mid_res_drained", res_q.size(), 0);
    t1 = tx_count;
    tick(300);
    check("reset_mid_tx_stopped", tx_count - t1, 0);
    check("reset_mid_sent", t1 - t0, 300);
    check("reset_mid_no_done", {busy, 32'(done_count - d0)}, 0);

    // Restarted frame begins again at pixel 0
    t0 = tx_count; d0 = done_count;
    push_frame();
    pulse_go();
    check("restart_pix_addr", {busy, pix_addr}, {1'b1, 10'd0});
    send_results();
    wait_done(d0 + 1, "restart_done");
    check("restart_tx_bytes", tx_count - t0, NP);

    // TX-only instance: image starts at once, rx bytes ignored
    r0 = res_count;
    for (int i = 0; i < NP; i++) begin
      k = 10'(i);
      txb_q.push_back(k[7:0]);
    end
    go_b = 1'b1; tick(1); go_b = 1'b0;
    check("b_starts_tx", {busy_b, pix_addr_b}, {1'b1, 10'd0});
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    n = 0;
    while (doneb_count == 0 && n < 20000) begin tick(1); n++; end
    check("b_done", doneb_count, 1);
    check("b_tx_bytes", txb_count, NP);
    check("b_no_res", resb_count, 0);
    check("idle_a_ignores_rx", res_count - r0, 0);
    check("b_queue_empty", txb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
